// File: rtl/exu_mdu_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide unit.
interface exu_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_pip_flush;
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [4:0]      i_rd_addr;
    logic            o_busy;
    logic            o_valid;
    logic            o_rd_wen;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_pip_flush, i_valid, i_funct3, i_rs1, i_rs2, i_rd_addr,
        input  o_ready, o_busy, o_valid, o_rd_wen, o_rd_addr, o_result
    );

    modport slave (
        input  i_pip_flush, i_valid, i_funct3, i_rs1, i_rs2, i_rd_addr,
        output o_ready, o_busy, o_valid, o_rd_wen, o_rd_addr, o_result
    );
endinterface

// File: rtl/exu_mdu.sv
// Multi-cycle RV32M multiply/divide unit for the EX stage.
// Optional macro EXU_MDU_EARLY_OUT_EN: divides with |dividend| < |divisor| finish at accept.
module exu_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DIV_STEP = 1
) (
    input logic    clk_sys,
    input logic    rst_sys,
    exu_mdu_if.slave mdu
);
    localparam int unsigned NITER = XLEN / DIV_STEP;
    localparam int unsigned CW    = $clog2(NITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(NITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_op;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_a, r_b, r_rem, r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_q, r_neg_r;

    logic            w_accept, w_signed, w_s1, w_s2;
    logic            w_div0, w_ovf, w_early, w_special;
    logic [XLEN-1:0] w_abs1, w_abs2, w_spec_res;
    logic            w_mul_sa, w_mul_sb;
    logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem_n, w_quo_n, w_q_fix, w_r_fix;

    assign w_accept = mdu.i_valid & (r_state == S_IDLE) & ~mdu.i_pip_flush;
    assign w_signed = ~mdu.i_funct3[0];
    assign w_s1     = w_signed & mdu.i_rs1[XLEN-1];
    assign w_s2     = w_signed & mdu.i_rs2[XLEN-1];
    assign w_abs1   = w_s1 ? -mdu.i_rs1 : mdu.i_rs1;
    assign w_abs2   = w_s2 ? -mdu.i_rs2 : mdu.i_rs2;
    assign w_div0   = (mdu.i_rs2 == '0);
    assign w_ovf    = w_signed & (mdu.i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (mdu.i_rs2 == '1);
`ifdef EXU_MDU_EARLY_OUT_EN
    assign w_early  = (w_abs1 < w_abs2);
`else
    assign w_early  = 1'b0;
`endif
    assign w_special = mdu.i_funct3[2] & (w_div0 | w_ovf | w_early);

    // funct3[1] separates remainder ops from quotient ops
    always_comb begin
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = mdu.i_funct3[1] ? mdu.i_rs1 : '1;
        else if (w_ovf)
            w_spec_res = mdu.i_funct3[1] ? '0 : mdu.i_rs1;
        else
            w_spec_res = mdu.i_funct3[1] ? mdu.i_rs1 : '0;
    end

    // Extending both operands to 2*XLEN makes one modular multiply serve all sign mixes
    assign w_mul_sa  = (r_op == 2'd1) | (r_op == 2'd2);
    assign w_mul_sb  = (r_op == 2'd1);
    assign w_mul_a   = {{XLEN{w_mul_sa & r_a[XLEN-1]}}, r_a};
    assign w_mul_b   = {{XLEN{w_mul_sb & r_b[XLEN-1]}}, r_b};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_mul_res = (r_op == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // r_a shifts the dividend out at the top while quotient bits enter at the bottom
    always_comb begin
        w_rem_n = r_rem;
        w_quo_n = r_a;
        w_trial = '0;
        for (int unsigned i = 0; i < DIV_STEP; i++) begin
            w_trial = {w_rem_n, w_quo_n[XLEN-1]} - {1'b0, r_b};
            if (!w_trial[XLEN])
                w_rem_n = w_trial[XLEN-1:0];
            else
                w_rem_n = {w_rem_n[XLEN-2:0], w_quo_n[XLEN-1]};
            w_quo_n = {w_quo_n[XLEN-2:0], ~w_trial[XLEN]};
        end
    end

    assign w_q_fix = r_neg_q ? -w_quo_n : w_quo_n;
    assign w_r_fix = r_neg_r ? -w_rem_n : w_rem_n;

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (!mdu.i_funct3[2]) w_state_nxt = S_MUL;
                else if (w_special)   w_state_nxt = S_DONE;
                else                  w_state_nxt = S_DIV;
            end
            S_MUL:  w_state_nxt = S_DONE;
            S_DIV:  if (r_cnt == '0) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (mdu.i_pip_flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            r_op     <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= mdu.i_funct3[1:0];
            r_rd    <= mdu.i_rd_addr;
            r_cnt   <= CNT_LAST;
            r_rem   <= '0;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
            r_a     <= mdu.i_funct3[2] ? w_abs1 : mdu.i_rs1;
            r_b     <= mdu.i_funct3[2] ? w_abs2 : mdu.i_rs2;
            if (w_special) r_result <= w_spec_res;
        end else if (!mdu.i_pip_flush) begin
            if (r_state == S_MUL) r_result <= w_mul_res;
            if (r_state == S_DIV) begin
                r_a   <= w_quo_n;
                r_rem <= w_rem_n;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) r_result <= r_op[1] ? w_r_fix : w_q_fix;
            end
        end
    end

    assign mdu.o_ready   = (r_state == S_IDLE);
    assign mdu.o_busy    = mdu.i_valid | (r_state != S_IDLE);
    assign mdu.o_valid   = (r_state == S_DONE);
    assign mdu.o_rd_wen  = mdu.o_valid & (r_rd != 5'd0);
    assign mdu.o_rd_addr = r_rd;
    assign mdu.o_result  = r_result;
endmodule

// File: tb/tb_exu_mdu.sv
// Directed self-checking bench for exu_mdu (default XLEN=32, DIV_STEP=1).
module tb_exu_mdu;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DIV_STEP = 1;
    localparam int DIV_LAT = XLEN / DIV_STEP + 1;
`ifdef EXU_MDU_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = DIV_LAT;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_mdu_if #(.XLEN(XLEN)) bus();

    exu_mdu #(.XLEN(XLEN), .DIV_STEP(DIV_STEP)) dut (
        .clk_sys (clk),
        .rst_sys (rst),
        .mdu     (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          lat;
    logic [31:0] res;
    logic        wen;
    logic [4:0]  addr;

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int o_lat, output logic [31:0] o_res,
                          output logic o_wen, output logic [4:0] o_addr);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_funct3 = f3; bus.i_rs1 = a; bus.i_rs2 = b; bus.i_rd_addr = rd;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        o_lat = -1; o_res = 'x; o_wen = 1'bx; o_addr = 'x;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                o_lat = c; o_res = bus.o_result; o_wen = bus.o_rd_wen; o_addr = bus.o_rd_addr;
                break;
            end
        end
    endtask

    task automatic chk_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        run_op(f3, a, b, 5'd1, lat, res, wen, addr);
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (res !== exp_res) begin
            n_fail++; $display("FAIL %s_result: got %h expected %h", name, res, exp_res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_pip_flush = 1'b0; bus.i_funct3 = '0;
        bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd_addr = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_rd_wen !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b/%b expected 0/0", bus.o_valid, bus.o_rd_wen);
        end
        n_checks++;
        if (bus.o_result !== 32'h0 || bus.o_rd_addr !== 5'd0) begin
            n_fail++; $display("FAIL reset_regs: got %h/%0d expected 0/0", bus.o_result, bus.o_rd_addr);
        end
        n_checks++;
        if (bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b/%b expected 1/0", bus.o_ready, bus.o_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(3'd0, 32'h7, 32'hFFFFFFFD, 5'd5, lat, res, wen, addr);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL mul_latency: got %0d expected 2", lat); end
        n_checks++;
        if (res !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
        n_checks++;
        if (wen !== 1'b1 || addr !== 5'd5) begin
            n_fail++; $display("FAIL mul_rd: got wen=%b addr=%0d expected wen=1 addr=5", wen, addr);
        end
        chk_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 2, 32'h40000000);
        chk_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFF);
        chk_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE);
        chk_op("mulh_neg_pos", 3'd1, 32'hFFFFFFFF, 32'h00000002, 2, 32'hFFFFFFFF);
    endtask

    task automatic test_div();
        chk_op("div_neg",  3'd4, 32'hFFFFFFEC, 32'h3, DIV_LAT, 32'hFFFFFFFA);
        chk_op("rem_neg",  3'd6, 32'hFFFFFFEC, 32'h3, DIV_LAT, 32'hFFFFFFFE);
        chk_op("divu",     3'd5, 32'd100, 32'd7, DIV_LAT, 32'd14);
        chk_op("remu",     3'd7, 32'd100, 32'd7, DIV_LAT, 32'd2);
        chk_op("div_negb", 3'd4, 32'd20, 32'hFFFFFFFD, DIV_LAT, 32'hFFFFFFFA);
        chk_op("rem_negb", 3'd6, 32'd20, 32'hFFFFFFFD, DIV_LAT, 32'd2);
        chk_op("divu_max", 3'd5, 32'hFFFFFFFF, 32'd1, DIV_LAT, 32'hFFFFFFFF);
    endtask

    task automatic test_special();
        chk_op("divu_zero", 3'd5, 32'h1234, 32'h0, 1, 32'hFFFFFFFF);
        chk_op("remu_zero", 3'd7, 32'h1234, 32'h0, 1, 32'h1234);
        chk_op("div_zero",  3'd4, 32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFF);
        chk_op("rem_zero",  3'd6, 32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFB);
        chk_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        chk_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0);
    endtask

    task automatic test_flush();
        bit seen;
        chk_op("flush_pre", 3'd0, 32'd2, 32'd3, 2, 32'd6);
        // flush a divide in its cycle 10
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_funct3 = 3'd5; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; bus.i_rd_addr = 5'd4;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.i_pip_flush = 1'b1;
        @(posedge clk);
        #1 bus.i_pip_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_div_state: got valid=%b ready=%b expected 0/1", bus.o_valid, bus.o_ready);
        end
        n_checks++;
        if (bus.o_result !== 32'd6) begin
            n_fail++; $display("FAIL flush_div_result: got %h expected 00000006", bus.o_result);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.o_valid) seen = 1'b1; end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_div_quiet: got valid pulse expected none"); end
        chk_op("flush_post_mul", 3'd0, 32'd5, 32'd6, 2, 32'd30);

        // flush while in the multiply cycle
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_funct3 = 3'd0; bus.i_rs1 = 32'd9; bus.i_rs2 = 32'd9;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        @(negedge clk);
        bus.i_pip_flush = 1'b1;
        @(posedge clk);
        #1 bus.i_pip_flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_valid !== 1'b0 || bus.o_result !== 32'd30) begin
            n_fail++; $display("FAIL flush_mul: got valid=%b result=%h expected 0/0000001e", bus.o_valid, bus.o_result);
        end

        // flush coincident with a request: not accepted
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_pip_flush = 1'b1; bus.i_funct3 = 3'd0; bus.i_rs1 = 32'd3; bus.i_rs2 = 32'd3;
        @(posedge clk);
        #1 begin bus.i_valid = 1'b0; bus.i_pip_flush = 1'b0; end
        @(negedge clk);
        n_checks++;
        if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept_ready: got %b expected 1", bus.o_ready); end
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (bus.o_valid) seen = 1'b1; end
        n_checks++;
        if (seen !== 1'b0 || bus.o_result !== 32'd30) begin
            n_fail++; $display("FAIL flush_accept_quiet: got seen=%b result=%h expected 0/0000001e", seen, bus.o_result);
        end
    endtask

    task automatic test_rd0();
        run_op(3'd0, 32'd2, 32'd2, 5'd0, lat, res, wen, addr);
        n_checks++;
        if (lat !== 2 || res !== 32'd4) begin
            n_fail++; $display("FAIL rd0_result: got lat=%0d res=%h expected 2/00000004", lat, res);
        end
        n_checks++;
        if (wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen: got %b expected 0", wen); end
    endtask

    task automatic test_early();
        chk_op("early_divu", 3'd5, 32'd3, 32'd10, EARLY_LAT, 32'd0);
        chk_op("early_remu", 3'd7, 32'd3, 32'd10, EARLY_LAT, 32'd3);
        chk_op("early_rem",  3'd6, 32'hFFFFFFFD, 32'd10, EARLY_LAT, 32'hFFFFFFFD);
    endtask

    task automatic test_back_to_back();
        int first_c, second_c;
        logic [31:0] first_r, second_r;
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_funct3 = 3'd0; bus.i_rs1 = 32'd6; bus.i_rs2 = 32'd7; bus.i_rd_addr = 5'd2;
        #1;
        n_checks++;
        if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", bus.o_busy); end
        @(posedge clk);
        #1 begin bus.i_funct3 = 3'd5; bus.i_rs1 = 32'h1234; bus.i_rs2 = 32'h0; end
        first_c = -1; second_c = -1; first_r = 'x; second_r = 'x;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.o_valid && first_c < 0) begin first_c = c; first_r = bus.o_result; end
            else if (bus.o_valid && second_c < 0) begin second_c = c; second_r = bus.o_result; end
            if (bus.o_ready && bus.i_valid) begin
                @(posedge clk);
                #1 bus.i_valid = 1'b0;
            end
        end
        n_checks++;
        if (first_c !== 2 || first_r !== 32'd42) begin
            n_fail++; $display("FAIL b2b_first: got cyc=%0d res=%h expected 2/0000002a", first_c, first_r);
        end
        n_checks++;
        if (second_c !== 4 || second_r !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL b2b_second: got cyc=%0d res=%h expected 4/ffffffff", second_c, second_r);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_funct3 = 3'd4; bus.i_rs1 = 32'd100; bus.i_rs2 = 32'd7; bus.i_rd_addr = 5'd9;
        @(posedge clk);
        #1 bus.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #2;
        n_checks++;
        if (bus.o_ready !== 1'b1 || bus.o_result !== 32'h0 || bus.o_rd_addr !== 5'd0) begin
            n_fail++; $display("FAIL reset_midop: got ready=%b res=%h rd=%0d expected 1/0/0",
                               bus.o_ready, bus.o_result, bus.o_rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        chk_op("post_reset_mul", 3'd0, 32'd11, 32'd3, 2, 32'd33);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_rd0();
        test_early();
        test_back_to_back();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
